proc_run_ctrl: RTL and testbench
================================

Name: proc_run_ctrl

Overview:
- Run-control sequencer for the Z processor.
- Accepts a program from a host over a valid/ready stream and writes it into instruction RAM through the processor's addr/wr/wdata load port.
- Appends NOP padding, asserts working long enough to fetch and fully drain the 4-stage pipeline, then steps rID through r0..r7 and streams the register values back to the host.
- Sits between the host/testbench and the processor top level.

Parameters:
- ADDR_W, 9, RAM address width; matches the processor addr port.
- DEPTH, 512, instruction RAM words.
- PAD_WORDS, 4, zero (NOP) words appended after the program so the drain fetches are defined.
- NREGS, 8, registers dumped (r0..r7).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse in IDLE begins a session; ignored otherwise.
- ld_valid  in  1  host program word valid.
- ld_ready  out  1  controller accepts a word.
- ld_data  in  32  instruction word.
- ld_last  in  1  marks the final program word.
- addr  out  ADDR_W  RAM load address to processor.
- wr  out  1  RAM write strobe to processor.
- wdata  out  32  RAM write data to processor.
- working  out  1  processor run enable.
- rID  out  4  register select to processor.
- rdata  in  32  selected register value from processor (combinational).
- dump_valid  out  1  register value valid.
- dump_ready  in  1  host accepts the dump beat.
- dump_id  out  3  register index of the current beat.
- dump_data  out  32  register value.
- busy  out  1  not IDLE and not DONE.
- done  out  1  session complete; held until the next start.
- err  out  1  program overflow; sticky until reset.

Behaviour:
- Reset values:
  - all outputs 0, except rID = 4'hF.
  - state IDLE, counters 0.
  - reset mid-session aborts immediately; working drops on the next edge.
- States:
  - IDLE -> LOAD on start.
  - LOAD: ld_ready = 1. A handshake (ld_valid & ld_ready) registers wr = 1, addr = wcnt, wdata = ld_data on the next cycle (1-cycle latency); wcnt++. On a handshake with ld_last: len = wcnt+1, go to PAD.
  - PAD: ld_ready = 0. Issues PAD_WORDS writes of 32'h0, one per cycle, at addr len..len+PAD_WORDS-1, then go to RUN.
  - RUN: working = 1 for exactly len+PAD_WORDS consecutive cycles (run counter), then working = 0 and go to DUMP.
  - DUMP: for i = 0..NREGS-1:
    - drive rID = i for one cycle;
    - on the next edge capture rdata into dump_data, dump_id = i, dump_valid = 1;
    - hold all three stable until dump_ready, then advance.
    - After beat NREGS-1 is accepted: go to DONE, rID = 4'hF.
  - DONE: done = 1. start -> LOAD, clearing done, counters and len; DONE -> LOAD is the only exit from DONE other than reset.
- Overflow: a handshake when wcnt+PAD_WORDS >= DEPTH is not written; err = 1 and go to DONE with no run or dump.
- Invalid inputs:
  - ld_ready = 0 outside LOAD, so ld_valid there is ignored.
  - A start pulse while busy is ignored.
  - A start pulse coinciding with reset is ignored (reset wins).
- Output rules:
  - wr is never asserted in the same cycle as working.
  - addr = 0 whenever wr = 0.
- Counter widths: wcnt and the run counter are ADDR_W+1 bits; no wrap occurs, because overflow is trapped first.

Optional Feature:
- Macro: PROC_RUN_STEP_EN.
- With the macro defined: extra input step (1 bit). In RUN, working is asserted for one cycle per step pulse instead of continuously; the run counter advances only on asserted cycles; otherwise identical.
- Without the macro: no step port; RUN is free-running.

Decomposition:
- Shared package proc_z_pkg:
  - state enum (IDLE, LOAD, PAD, RUN, DUMP, DONE);
  - opcode constants IRMOV = 8'h10, ADD = 8'h20, SUB = 8'h21, AND = 8'h22, XOR = 8'h23;
  - NOP_WORD = 32'h0;
  - RID_IDLE = 4'hF.
- Sub-module proc_dump_seq: rID stepping, capture and dump valid/ready handshake; started by a one-cycle go pulse, returns a fin pulse.

Test Plan:
- Program load: start, then 12 words 10F00080..10F70087, 20010000, 21230000, 22450000, 23670000 (last on the final word) -> wr strobes at addr 0..11 with matching data, then addr 12..15 with wdata 0; working high for exactly 16 cycles.
- Dump of the same run: dump beats in order r0..r7 = 0x101, 0x81, 0xFFFFFFFF, 0x83, 0x84, 0x85, 0x01, 0x87. Then done = 1 and rID = 4'hF.
- Backpressure: hold dump_ready low for 5 cycles on beat 3 -> dump_valid, dump_id = 3 and dump_data stay stable; there is no skip or duplicate beat.
- Overflow: a 509-word stream with DEPTH 512 -> words 0..507 written, word 508 not written, err = 1, done = 1, working never asserted.
- Reset mid-RUN: assert reset in run cycle 5 -> next edge working = 0, rID = 4'hF, state IDLE. A new start then reloads correctly.
- PROC_RUN_STEP_EN: 3 step pulses on a 1-word program -> working high exactly 3 cycles; 2 more pulses -> DUMP begins.

Source files
------------

// File: rtl/proc_z_pkg.sv
// Shared types and constants for the Z processor run-control slice.
// No ports: state encodings, opcodes, NOP word, idle register select.
package proc_z_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD,
      RUN,
      DUMP,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      D_IDLE,
      D_SEL,
      D_BEAT
   } dstate_t;

   localparam logic [7:0] IRMOV = 8'h10;
   localparam logic [7:0] ADD   = 8'h20;
   localparam logic [7:0] SUB   = 8'h21;
   localparam logic [7:0] AND   = 8'h22;
   localparam logic [7:0] XOR   = 8'h23;

   localparam logic [31:0] NOP_WORD = 32'h0;
   localparam logic [3:0]  RID_IDLE = 4'hF;

endpackage

// File: rtl/proc_dump_seq.sv
// Register dump sequencer: steps rID, captures rdata, runs the dump handshake.
// Ports: clock/reset, go (start pulse), rdata in, dump_ready in,
//        rID, dump_valid/dump_id/dump_data out, fin (last beat accepted).
import proc_z_pkg::*;

module proc_dump_seq #(
   parameter int NREGS = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        go,
   input  logic [31:0] rdata,
   input  logic        dump_ready,
   output logic [3:0]  rID,
   output logic        dump_valid,
   output logic [2:0]  dump_id,
   output logic [31:0] dump_data,
   output logic        fin
);

   localparam logic [2:0] LAST = 3'(NREGS - 1);

   dstate_t     st, st_n;
   logic [2:0]  idx, idx_n;
   logic [3:0]  rid_q, rid_n;
   logic        vld_q, vld_n;
   logic [2:0]  id_q, id_n;
   logic [31:0] dat_q, dat_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         st    <= D_IDLE;
         idx   <= '0;
         rid_q <= RID_IDLE;
         vld_q <= 1'b0;
         id_q  <= '0;
         dat_q <= '0;
      end else begin
         st    <= st_n;
         idx   <= idx_n;
         rid_q <= rid_n;
         vld_q <= vld_n;
         id_q  <= id_n;
         dat_q <= dat_n;
      end
   end

   // rID selects a register for exactly the SEL cycle; the beat
   // itself is carried by the captured copy, so rID parks at idle.
   always_comb begin
      st_n  = st;
      idx_n = idx;
      rid_n = rid_q;
      vld_n = vld_q;
      id_n  = id_q;
      dat_n = dat_q;
      fin   = 1'b0;
      unique case (st)
         D_IDLE: begin
            if (go) begin
               st_n  = D_SEL;
               idx_n = '0;
               rid_n = 4'h0;
            end
         end
         D_SEL: begin
            st_n  = D_BEAT;
            dat_n = rdata;
            id_n  = idx;
            vld_n = 1'b1;
            rid_n = RID_IDLE;
         end
         D_BEAT: begin
            if (dump_ready) begin
               vld_n = 1'b0;
               if (idx == LAST) begin
                  fin  = 1'b1;
                  st_n = D_IDLE;
               end else begin
                  idx_n = idx + 3'd1;
                  rid_n = {1'b0, idx + 3'd1};
                  st_n  = D_SEL;
               end
            end
         end
         default: st_n = D_IDLE;
      endcase
   end

   assign rID        = rid_q;
   assign dump_valid = vld_q;
   assign dump_id    = id_q;
   assign dump_data  = dat_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run-control sequencer: load program, pad with NOPs, run, dump r0..r7.
// Ports: clock/reset/start; ld_* program stream; addr/wr/wdata RAM port;
//        working, rID, rdata to processor; dump_* stream; busy/done/err.
// Optional macro PROC_RUN_STEP_EN adds a step input for single-cycle runs.
import proc_z_pkg::*;

module proc_run_ctrl #(
   parameter int ADDR_W    = 9,
   parameter int DEPTH     = 512,
   parameter int PAD_WORDS = 4,
   parameter int NREGS     = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
`ifdef PROC_RUN_STEP_EN
   input  logic              step,
`endif
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [31:0]       ld_data,
   input  logic              ld_last,
   output logic [ADDR_W-1:0] addr,
   output logic              wr,
   output logic [31:0]       wdata,
   output logic              working,
   output logic [3:0]        rID,
   input  logic [31:0]       rdata,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [2:0]        dump_id,
   output logic [31:0]       dump_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = ADDR_W + 1;

   state_t            state, state_n;
   logic [CW-1:0]     wcnt, wcnt_n;
   logic [CW-1:0]     len, len_n;
   logic [CW-1:0]     pcnt, pcnt_n;
   logic [CW-1:0]     rcnt, rcnt_n;
   logic              wr_q, wr_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [31:0]       wdata_q, wdata_n;
   logic              err_q, err_n;
   logic [CW-1:0]     total;
   logic              adv;
   logic              go;
   logic              fin;

   assign total = len + CW'(PAD_WORDS);

`ifdef PROC_RUN_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         wcnt    <= '0;
         len     <= '0;
         pcnt    <= '0;
         rcnt    <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         wcnt    <= wcnt_n;
         len     <= len_n;
         pcnt    <= pcnt_n;
         rcnt    <= rcnt_n;
         wr_q    <= wr_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         err_q   <= err_n;
      end
   end

   // RAM writes are registered, so the last pad write lands in the
   // cycle PAD sees pcnt == PAD_WORDS; RUN starts one cycle later.
   always_comb begin
      state_n  = state;
      wcnt_n   = wcnt;
      len_n    = len;
      pcnt_n   = pcnt;
      rcnt_n   = rcnt;
      wr_n     = 1'b0;
      addr_n   = '0;
      wdata_n  = NOP_WORD;
      err_n    = err_q;
      ld_ready = 1'b0;
      working  = 1'b0;
      go       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = LOAD;
               wcnt_n  = '0;
               len_n   = '0;
            end
         end
         LOAD: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               if (wcnt + CW'(PAD_WORDS) >= CW'(DEPTH)) begin
                  err_n   = 1'b1;
                  state_n = DONE;
               end else begin
                  wr_n    = 1'b1;
                  addr_n  = wcnt[ADDR_W-1:0];
                  wdata_n = ld_data;
                  wcnt_n  = wcnt + CW'(1);
                  if (ld_last) begin
                     len_n   = wcnt + CW'(1);
                     pcnt_n  = '0;
                     state_n = PAD;
                  end
               end
            end
         end
         PAD: begin
            if (pcnt == CW'(PAD_WORDS)) begin
               state_n = RUN;
               rcnt_n  = '0;
            end else begin
               wr_n   = 1'b1;
               addr_n = len[ADDR_W-1:0] + pcnt[ADDR_W-1:0];
               pcnt_n = pcnt + CW'(1);
            end
         end
         RUN: begin
            working = adv;
            if (adv) begin
               if (rcnt == total - CW'(1)) begin
                  state_n = DUMP;
                  go      = 1'b1;
               end else begin
                  rcnt_n = rcnt + CW'(1);
               end
            end
         end
         DUMP: begin
            if (fin) state_n = DONE;
         end
         DONE: begin
            if (start) begin
               state_n = LOAD;
               wcnt_n  = '0;
               len_n   = '0;
               pcnt_n  = '0;
               rcnt_n  = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   proc_dump_seq #(
      .NREGS(NREGS)
   ) u_dump (
      .clock      (clock),
      .reset      (reset),
      .go         (go),
      .rdata      (rdata),
      .dump_ready (dump_ready),
      .rID        (rID),
      .dump_valid (dump_valid),
      .dump_id    (dump_id),
      .dump_data  (dump_data),
      .fin        (fin)
   );

   assign addr  = addr_q;
   assign wr    = wr_q;
   assign wdata = wdata_q;
   assign busy  = (state != IDLE) && (state != DONE);
   assign done  = (state == DONE);
   assign err   = err_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl with a small Z processor model.
// Checks load, pad, run length, dump order/backpressure, overflow, reset.
module tb_proc_run_ctrl;
   import proc_z_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_data = '0;
   logic        ld_last = 1'b0;
   logic        dump_ready = 1'b0;
`ifdef PROC_RUN_STEP_EN
   logic        step = 1'b1;
`endif
   logic        ld_ready;
   logic [8:0]  addr;
   logic        wr;
   logic [31:0] wdata;
   logic        working;
   logic [3:0]  rID;
   logic [31:0] rdata;
   logic        dump_valid;
   logic [2:0]  dump_id;
   logic [31:0] dump_data;
   logic        busy;
   logic        done;
   logic        err;

   proc_run_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
`ifdef PROC_RUN_STEP_EN
      .step       (step),
`endif
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .addr       (addr),
      .wr         (wr),
      .wdata      (wdata),
      .working    (working),
      .rID        (rID),
      .rdata      (rdata),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_id    (dump_id),
      .dump_data  (dump_data),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clock = ~clock;

   logic [31:0] regs [8];
   logic [31:0] ram [512];
   int          pc = 0;
   assign rdata = (rID < 4'd8) ? regs[rID[2:0]] : 32'h0;

   int          errors = 0;
   int          checks = 0;
   int          nwr = 0;
   int          wcyc = 0;
   int          wrises = 0;
   logic        prev_work = 1'b0;
   logic        overlap = 1'b0;
   logic        addr_bad = 1'b0;
   logic [8:0]  wlog_a [600];
   logic [31:0] wlog_d [600];

   logic [31:0] prog [12];
   logic [31:0] exp_regs [8];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic exec(input logic [31:0] w);
      logic [7:0] op;
      logic [2:0] a;
      logic [2:0] b;
      op = w[31:24];
      a  = w[22:20];
      b  = w[18:16];
      case (op)
         IRMOV:   regs[b] = {16'h0, w[15:0]};
         ADD:     regs[a] = regs[a] + regs[b];
         SUB:     regs[a] = regs[a] - regs[b];
         AND:     regs[a] = regs[a] & regs[b];
         XOR:     regs[a] = regs[a] ^ regs[b];
         default: ;
      endcase
   endtask

   // Values seen here belong to the cycle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] = '0;
         pc = 0;
      end
      if (wr) begin
         ram[addr] = wdata;
         if (nwr < 600) begin
            wlog_a[nwr] = addr;
            wlog_d[nwr] = wdata;
         end
         nwr++;
         pc = 0;
      end
      if (!wr && addr != 9'd0) addr_bad = 1'b1;
      if (wr && working) overlap = 1'b1;
      if (working) begin
         exec(ram[pc[8:0]]);
         pc++;
         wcyc++;
         if (!prev_work) wrises++;
      end
      prev_work = working;
   endtask

   task automatic clr_log();
      nwr = 0;
      wcyc = 0;
      wrises = 0;
      overlap = 1'b0;
      addr_bad = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_dump(input string tag);
      for (int k = 0; k < 100 && !dump_valid; k++) tick();
      check(tag, 32'(dump_valid), 32'd1);
   endtask

   task automatic drain(input bit chk_data, input bit bp);
      logic [31:0] hold_d;
      logic        stable;
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < 20 && !dump_valid; k++) tick();
         check($sformatf("beat%0d_valid", b), 32'(dump_valid), 32'd1);
         check($sformatf("beat%0d_id", b), 32'(dump_id), 32'(b));
         if (chk_data)
            check($sformatf("beat%0d_data", b), dump_data, exp_regs[b]);
         if (bp && b == 3) begin
            stable = 1'b1;
            hold_d = dump_data;
            repeat (5) begin
               tick();
               if (!dump_valid || dump_id != 3'd3 || dump_data != hold_d)
                  stable = 1'b0;
            end
            check("bp_stable", 32'(stable), 32'd1);
         end
         dump_ready = 1'b1;
         tick();
         dump_ready = 1'b0;
      end
      check("dump_done", 32'(done), 32'd1);
      check("dump_rid_idle", 32'(rID), 32'hF);
      check("dump_valid_low", 32'(dump_valid), 32'd0);
   endtask

   task automatic load_prog();
      for (int i = 0; i < 12; i++) send(prog[i], i == 11);
   endtask

   initial begin
      for (int i = 0; i < 8; i++)
         prog[i] = 32'h10F0_0080 + (32'(i) << 16) + 32'(i);
      prog[8]  = 32'h2001_0000;
      prog[9]  = 32'h2123_0000;
      prog[10] = 32'h2245_0000;
      prog[11] = 32'h2367_0000;
      exp_regs = '{32'h101, 32'h81, 32'hFFFF_FFFF, 32'h83,
                   32'h84, 32'h85, 32'h1, 32'h87};

      // reset state
      reset = 1'b1;
      repeat (3) tick();
      check("rst_wr", 32'(wr), 32'd0);
      check("rst_working", 32'(working), 32'd0);
      check("rst_rid", 32'(rID), 32'hF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_dump_valid", 32'(dump_valid), 32'd0);
      reset = 1'b0;
      tick();

      // session 1: 12-word program, run, dump with backpressure
      clr_log();
      kick();
      check("s1_ld_ready", 32'(ld_ready), 32'd1);
      check("s1_busy", 32'(busy), 32'd1);
      load_prog();
      wait_dump("s1_dump_start");
      check("s1_nwr", 32'(nwr), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("s1_waddr%0d", i), 32'(wlog_a[i]), 32'(i));
         check($sformatf("s1_wdata%0d", i), wlog_d[i],
               (i < 12) ? prog[i] : 32'h0);
      end
      check("s1_run_cycles", 32'(wcyc), 32'd16);
      check("s1_run_rises", 32'(wrises), 32'd1);
      check("s1_wr_work_overlap", 32'(overlap), 32'd0);
      check("s1_addr_idle_zero", 32'(addr_bad), 32'd0);
      drain(1'b1, 1'b1);
      check("s1_err", 32'(err), 32'd0);

      // ld_valid outside LOAD is ignored
      ld_valid = 1'b1;
      tick();
      check("done_ld_ready", 32'(ld_ready), 32'd0);
      ld_valid = 1'b0;

      // session 2: overflow with a 509-word stream
      clr_log();
      kick();
      for (int i = 0; i < 509; i++)
         send(32'hA000_0000 + 32'(i), i == 508);
      tick();
      tick();
      check("ov_nwr", 32'(nwr), 32'd508);
      check("ov_last_addr", 32'(wlog_a[507]), 32'd507);
      check("ov_last_data", wlog_d[507], 32'hA000_01FB);
      check("ov_err", 32'(err), 32'd1);
      check("ov_done", 32'(done), 32'd1);
      check("ov_busy", 32'(busy), 32'd0);
      check("ov_no_run", 32'(wcyc), 32'd0);
      check("ov_no_dump", 32'(dump_valid), 32'd0);
      check("ov_ld_ready", 32'(ld_ready), 32'd0);

      // session 3: reset in run cycle 5, then reload
      clr_log();
      kick();
      load_prog();
      for (int k = 0; k < 50 && !working; k++) tick();
      check("rr_run_seen", 32'(working), 32'd1);
      repeat (4) tick();
      check("rr_cycle5", 32'(wcyc), 32'd5);
      reset = 1'b1;
      tick();
      check("rr_working", 32'(working), 32'd0);
      check("rr_rid", 32'(rID), 32'hF);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_done", 32'(done), 32'd0);
      check("rr_err_clr", 32'(err), 32'd0);
      reset = 1'b0;
      tick();
      clr_log();
      kick();
      load_prog();
      wait_dump("rl_dump_start");
      check("rl_nwr", 32'(nwr), 32'd16);
      check("rl_run_cycles", 32'(wcyc), 32'd16);
      check("rl_overlap", 32'(overlap), 32'd0);
      drain(1'b1, 1'b0);

`ifdef PROC_RUN_STEP_EN
      // session 4: single-step a 1-word program
      begin
         int scnt;
         scnt = 0;
         step = 1'b0;
         clr_log();
         kick();
         send(32'h10F3_0042, 1'b1);
         repeat (10) tick();
         check("st_idle_run", 32'(wcyc), 32'd0);
         for (int p = 0; p < 5; p++) begin
            step = 1'b1;
            #1;
            if (working) scnt++;
            @(posedge clock);
            #1;
            step = 1'b0;
            tick();
            tick();
            if (p == 2) begin
               check("st_three", 32'(scnt), 32'd3);
               check("st_still_busy", 32'(busy), 32'd1);
               check("st_no_dump", 32'(dump_valid), 32'd0);
            end
         end
         check("st_five", 32'(scnt), 32'd5);
         check("st_no_free_run", 32'(wcyc), 32'd0);
         wait_dump("st_dump_start");
         drain(1'b0, 1'b0);
         step = 1'b1;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
